// File: rtl/vedic_operand_driver.sv
// Operand/result master for the non-pipelined Vedic multiplier stream.
// Optional self-check of returned products: define VEDIC_DRV_CHECK_EN.
module vedic_operand_driver #(
  parameter int DATA_W         = 2,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 16
) (
  input  logic                clk,
  input  logic                arst_n,
  input  logic [2*DATA_W-1:0] s_op_tdata,
  input  logic                s_op_tvalid,
  output logic                s_op_tready,
  output logic [DATA_W-1:0]   m_a_tdata,
  output logic                m_a_tvalid,
  input  logic                m_a_tready,
  output logic [DATA_W-1:0]   m_b_tdata,
  output logic                m_b_tvalid,
  input  logic                m_b_tready,
  input  logic [2*DATA_W-1:0] s_result_tdata,
  input  logic                s_result_tvalid,
  output logic                s_result_tready,
  output logic [2*DATA_W-1:0] m_prod_tdata,
  output logic                m_prod_tuser,
  output logic                m_prod_tvalid,
  input  logic                m_prod_tready,
  output logic [CNT_W-1:0]    op_count,
  output logic                busy
`ifdef VEDIC_DRV_CHECK_EN
  ,
  output logic                mismatch,
  output logic [CNT_W-1:0]    err_count
`endif
);

  localparam int PW = 2 * DATA_W;
  localparam int TW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST =
    TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RES,
    DELIVER
  } state_e;

  state_e            state_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic              a_vld_q;
  logic              b_vld_q;
  logic [PW-1:0]     prod_q;
  logic              user_q;
  logic              pvld_q;
  logic              stale_q;
  logic [TW-1:0]     tmo_q;
  logic [CNT_W-1:0]  cnt_q;

  logic op_hs;
  logic res_hs;
  logic prod_hs;
  logic a_done;
  logic b_done;
  logic tmo_hit;

  assign s_op_tready     = (state_q == IDLE) && !stale_q;
  // stale_q is only ever set outside WAIT_RES
  assign s_result_tready = (state_q == WAIT_RES) || stale_q;

  assign op_hs   = s_op_tvalid && s_op_tready;
  assign res_hs  = s_result_tvalid && s_result_tready;
  assign prod_hs = pvld_q && m_prod_tready;
  assign a_done  = !a_vld_q || m_a_tready;
  assign b_done  = !b_vld_q || m_b_tready;
  assign tmo_hit = TMO_EN && (tmo_q == TMO_LAST);

  assign m_a_tdata     = a_q;
  assign m_a_tvalid    = a_vld_q;
  assign m_b_tdata     = b_q;
  assign m_b_tvalid    = b_vld_q;
  assign m_prod_tdata  = prod_q;
  assign m_prod_tuser  = user_q;
  assign m_prod_tvalid = pvld_q;
  assign op_count      = cnt_q;
  assign busy          = (state_q != IDLE) || stale_q;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      a_vld_q <= 1'b0;
      b_vld_q <= 1'b0;
      prod_q  <= '0;
      user_q  <= 1'b0;
      pvld_q  <= 1'b0;
      stale_q <= 1'b0;
      tmo_q   <= '0;
      cnt_q   <= '0;
    end else begin
      if (stale_q && res_hs) stale_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (op_hs) begin
            a_q     <= s_op_tdata[DATA_W-1:0];
            b_q     <= s_op_tdata[PW-1:DATA_W];
            a_vld_q <= 1'b1;
            b_vld_q <= 1'b1;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (m_a_tready) a_vld_q <= 1'b0;
          if (m_b_tready) b_vld_q <= 1'b0;
          if (a_done && b_done) begin
            tmo_q   <= '0;
            state_q <= WAIT_RES;
          end
        end
        WAIT_RES: begin
          tmo_q <= tmo_q + 1'b1;
          // a result arriving on the timeout cycle still wins
          if (res_hs) begin
            prod_q  <= s_result_tdata;
            user_q  <= 1'b0;
            pvld_q  <= 1'b1;
            state_q <= DELIVER;
          end else if (tmo_hit) begin
            prod_q  <= '0;
            user_q  <= 1'b1;
            pvld_q  <= 1'b1;
            stale_q <= 1'b1;
            state_q <= DELIVER;
          end
        end
        DELIVER: begin
          if (prod_hs) begin
            pvld_q  <= 1'b0;
            state_q <= IDLE;
            if (!user_q) cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef VEDIC_DRV_CHECK_EN
  logic [PW-1:0]    exp_q;
  logic             mm_q;
  logic [CNT_W-1:0] err_q;
  logic             chk_hs;
  logic             bad;

  assign chk_hs    = res_hs && (state_q == WAIT_RES);
  assign bad       = chk_hs && (s_result_tdata != exp_q);
  assign mismatch  = mm_q;
  assign err_count = err_q;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      exp_q <= '0;
      mm_q  <= 1'b0;
      err_q <= '0;
    end else begin
      if (op_hs) begin
        exp_q <= {{DATA_W{1'b0}}, s_op_tdata[DATA_W-1:0]} *
                 {{DATA_W{1'b0}}, s_op_tdata[PW-1:DATA_W]};
      end
      mm_q <= bad;
      if (bad && (err_q != '1)) err_q <= err_q + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_vedic_operand_driver.sv
// Scoreboard bench for vedic_operand_driver with a behavioural multiplier.
// Covers VEDIC_DRV_CHECK_EN ports when that macro is defined.
module tb_vedic_operand_driver;

  localparam int TMO = 8;
`ifdef VEDIC_DRV_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic       clk;
  logic       arst_n;
  logic [3:0] s_op_tdata;
  logic       s_op_tvalid;
  logic       s_op_tready;
  logic [1:0] m_a_tdata;
  logic       m_a_tvalid;
  logic       m_a_tready;
  logic [1:0] m_b_tdata;
  logic       m_b_tvalid;
  logic       m_b_tready;
  logic [3:0] s_result_tdata;
  logic       s_result_tvalid;
  logic       s_result_tready;
  logic [3:0] m_prod_tdata;
  logic       m_prod_tuser;
  logic       m_prod_tvalid;
  logic       m_prod_tready;
  logic [3:0] op_count;
  logic       busy;
`ifdef VEDIC_DRV_CHECK_EN
  logic       mismatch;
  logic [3:0] err_count;
`endif

  vedic_operand_driver #(
    .DATA_W(2),
    .TIMEOUT_CYCLES(TMO),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .arst_n(arst_n),
    .s_op_tdata(s_op_tdata),
    .s_op_tvalid(s_op_tvalid),
    .s_op_tready(s_op_tready),
    .m_a_tdata(m_a_tdata),
    .m_a_tvalid(m_a_tvalid),
    .m_a_tready(m_a_tready),
    .m_b_tdata(m_b_tdata),
    .m_b_tvalid(m_b_tvalid),
    .m_b_tready(m_b_tready),
    .s_result_tdata(s_result_tdata),
    .s_result_tvalid(s_result_tvalid),
    .s_result_tready(s_result_tready),
    .m_prod_tdata(m_prod_tdata),
    .m_prod_tuser(m_prod_tuser),
    .m_prod_tvalid(m_prod_tvalid),
    .m_prod_tready(m_prod_tready),
    .op_count(op_count),
    .busy(busy)
`ifdef VEDIC_DRV_CHECK_EN
    ,
    .mismatch(mismatch),
    .err_count(err_count)
`endif
  );

  int n_chk = 0;
  int n_fail = 0;
  int issued = 0;
  int delivered = 0;
  int pending_late = 0;
  int model_cnt = 0;
  int mm_pulses = 0;
  int n_corrupt = 0;

  logic [4:0] exp_q[$];
  logic [3:0] opnd_q[$];
  int         lat_q[$];
  bit         cor_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: run did not end (issued %0d delivered %0d)",
             issued, delivered);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic sink();
    int stall = 0;
    forever begin
      @(posedge clk); #1;
      if (stall > 0) begin
        m_prod_tready = 1'b0;
        stall--;
      end else if ($urandom_range(0, 24) == 0) begin
        m_prod_tready = 1'b0;
        stall = 9;
      end else begin
        m_prod_tready = ($urandom_range(0, 3) != 0);
      end
    end
  endtask

  task automatic mul_model();
    int pa, pb, d, r;
    bit ga, gb, cor, late, hs;
    logic [3:0] ab;
    forever begin
      ga = 0;
      gb = 0;
      while (!(ga && gb)) begin
        m_a_tready = !ga && ($urandom_range(0, 2) != 0);
        m_b_tready = !gb && ($urandom_range(0, 2) != 0);
        @(negedge clk);
        if (ga) chk("a_not_redriven", m_a_tvalid, 0);
        if (gb) chk("b_not_redriven", m_b_tvalid, 0);
        if (m_a_tvalid && m_a_tready) begin
          ga = 1;
          pa = int'(m_a_tdata);
        end
        if (m_b_tvalid && m_b_tready) begin
          gb = 1;
          pb = int'(m_b_tdata);
        end
        @(posedge clk); #1;
      end
      m_a_tready = 1'b0;
      m_b_tready = 1'b0;
      chk("operands_were_issued", 32'(lat_q.size() != 0), 1);
      if (lat_q.size() != 0) begin
        d = lat_q.pop_front();
        cor = cor_q.pop_front();
        ab = opnd_q.pop_front();
        chk("operand_a", 32'(pa), 32'(ab[1:0]));
        chk("operand_b", 32'(pb), 32'(ab[3:2]));
      end else begin
        d = 0;
        cor = 0;
      end
      repeat (d) begin
        @(posedge clk); #1;
      end
      late = (d >= TMO);
      r = late ? int'($urandom_range(0, 15)) : ((pa * pb) ^ int'(cor));
      s_result_tdata = 4'(r);
      s_result_tvalid = 1'b1;
      hs = 0;
      for (int g = 0; g < 300 && !hs; g++) begin
        @(negedge clk);
        hs = s_result_tready;
        @(posedge clk); #1;
      end
      chk("result_accept_bound", hs, 1);
      s_result_tvalid = 1'b0;
      if (late) pending_late--;
    end
  endtask

  task automatic monitor();
    logic [4:0] e;
    logic [3:0] pd_prev = '0;
    bit stall_prev = 0;
    bit post_hs = 0;
    forever begin
      @(negedge clk);
      chk("op_count", op_count, 32'(model_cnt % 16));
      if (post_hs) begin
        chk("op_ready_after_deliver", s_op_tready, pending_late == 0);
        post_hs = 0;
      end
      if (stall_prev) begin
        chk("prod_hold_valid", m_prod_tvalid, 1);
        chk("prod_hold_data", m_prod_tdata, pd_prev);
      end
`ifdef VEDIC_DRV_CHECK_EN
      if (mismatch) mm_pulses++;
`endif
      if (m_prod_tvalid && m_prod_tready) begin
        chk("prod_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("prod_data", m_prod_tdata, e[3:0]);
          chk("prod_tuser", m_prod_tuser, e[4]);
          if (!e[4]) model_cnt++;
        end
        delivered++;
        post_hs = 1;
      end
      stall_prev = m_prod_tvalid && !m_prod_tready;
      pd_prev = m_prod_tdata;
    end
  endtask

  task automatic send(input int a, input int b, input int d, input bit cor);
    bit hs = 0;
    int p;
    s_op_tdata = 4'((b << 2) | a);
    s_op_tvalid = 1'b1;
    for (int g = 0; g < 600 && !hs; g++) begin
      @(negedge clk);
      if (s_op_tready) begin
        hs = 1;
        chk("idle_when_accepting", 32'(issued - delivered), 0);
        chk("no_stale_at_accept", 32'(pending_late), 0);
        issued++;
        p = (a * b) ^ int'(cor);
        exp_q.push_back((d >= TMO) ? 5'b10000 : {1'b0, 4'(p)});
        lat_q.push_back(d);
        cor_q.push_back(cor);
        opnd_q.push_back(4'((b << 2) | a));
        if (d >= TMO) pending_late++;
        if (cor) n_corrupt++;
      end
      @(posedge clk); #1;
    end
    chk("op_accept_bound", hs, 1);
    s_op_tvalid = 1'b0;
    if (hs) begin
      @(negedge clk);
      chk("ab_valid_next_cycle", {m_a_tvalid, m_b_tvalid, s_op_tready},
          3'b110);
      chk("a_tdata", m_a_tdata, 32'(a));
      chk("b_tdata", m_b_tdata, 32'(b));
      @(posedge clk); #1;
    end
  endtask

  int da[8] = '{3, 3, 2, 1, 2, 3, 0, 3};
  int db[8] = '{2, 3, 1, 1, 3, 1, 3, 3};
  int dd[8] = '{3, 2, 9, 0, 7, 8, 0, 1};
  bit dc[8] = '{0, 0, 0, 0, 0, 0, 0, 1};

  initial begin
    bit drained;
    int d, r;
    arst_n = 1'b0;
    s_op_tdata = '0;
    s_op_tvalid = 1'b0;
    m_a_tready = 1'b0;
    m_b_tready = 1'b0;
    s_result_tdata = '0;
    s_result_tvalid = 1'b0;
    m_prod_tready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_op_ready", s_op_tready, 1);
    chk("rst_valids", {m_a_tvalid, m_b_tvalid, m_prod_tvalid}, 0);
    chk("rst_res_ready", s_result_tready, 0);
    chk("rst_prod", {m_prod_tuser, m_prod_tdata}, 0);
    chk("rst_count_busy", {op_count, busy}, 0);
    @(posedge clk); #1;
    arst_n = 1'b1;

    s_op_tdata = 4'hB;
    s_op_tvalid = 1'b1;
    m_a_tready = 1'b1;
    @(posedge clk); #1;
    s_op_tvalid = 1'b0;
    @(negedge clk);
    chk("mid_issue_ab_valid", {m_a_tvalid, m_b_tvalid}, 2'b11);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_issue_split", {m_a_tvalid, m_b_tvalid, busy}, 3'b011);
    #2 arst_n = 1'b0;
    #1;
    chk("async_rst_valids", {m_a_tvalid, m_b_tvalid, m_prod_tvalid}, 0);
    chk("async_rst_ready_busy", {s_op_tready, busy}, 2'b10);
    @(posedge clk); #1;
    arst_n = 1'b1;
    m_a_tready = 1'b1;
    m_b_tready = 1'b1;
    m_prod_tready = 1'b1;
    s_result_tdata = 4'h6;
    s_result_tvalid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_quiet", {m_prod_tvalid, m_a_tvalid, s_result_tready},
          0);
      chk("post_rst_op_ready", s_op_tready, 1);
    end
    s_result_tvalid = 1'b0;
    m_a_tready = 1'b0;
    m_b_tready = 1'b0;
    @(posedge clk); #1;

    fork
      sink();
      monitor();
      mul_model();
    join_none

    for (int i = 0; i < 8; i++) send(da[i], db[i], dd[i], dc[i] && CHK);
    for (int i = 0; i < 150; i++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      r = $urandom_range(0, 19);
      if (r < 14) d = $urandom_range(0, 4);
      else if (r < 16) d = TMO - 1;
      else if (r < 18) d = TMO;
      else d = $urandom_range(TMO + 1, TMO + 6);
      send($urandom_range(0, 3), $urandom_range(0, 3), d, 1'b0);
    end

    drained = 0;
    for (int g = 0; g < 3000 && !drained; g++) begin
      @(negedge clk);
      drained = (issued == delivered) && (pending_late == 0);
    end
    chk("drain_bound", drained, 1);
    repeat (3) @(negedge clk);
    chk("end_idle", {busy, s_op_tready, m_prod_tvalid}, 3'b010);
    chk("end_queue_empty", 32'(exp_q.size()), 0);
`ifdef VEDIC_DRV_CHECK_EN
    chk("mismatch_pulses", 32'(mm_pulses), 32'(n_corrupt));
    chk("err_count", err_count, 32'(n_corrupt));
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
